operand_stack: RTL and testbench
================================

OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 64, bit width of one stack entry (i32 values zero-extended, i64 native).
REQ-002 SHALL have parameter DEPTH, default 16, maximum entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port push  input  1  push data_in this cycle.
REQ-006 SHALL have port pop  input  2  number of entries to pop this cycle (0, 1, 2; 3 is illegal).
REQ-007 SHALL have port data_in  input  WIDTH  value pushed.
REQ-008 SHALL have port tos  output  WIDTH  top-of-stack entry.
REQ-009 SHALL have port nos  output  WIDTH  next-on-stack entry.
REQ-010 SHALL have port count  output  $clog2(DEPTH+1)  current entry count.
REQ-011 SHALL have port empty  output  1  count == 0.
REQ-012 SHALL have port full  output  1  count == DEPTH.
REQ-013 SHALL have port trap  output  3  0 none, 1 overflow, 2 underflow, 3 illegal pop code.

Function
REQ-014 Operations SHALL be evaluated at each rising clk edge; the combined operation is pop first, then push (e.g. pop=2,push=1 is a binary-op result, pop=1,push=1 replaces tos).
REQ-015 New count SHALL be count - pop + push; new tos SHALL be data_in when push=1, else the entry pop positions below old tos.
REQ-016 tos, nos, count, empty and full SHALL reflect the state after the latest edge with zero read latency (no extra cycle).
REQ-017 tos SHALL read 0 when count < 1; nos SHALL read 0 when count < 2.
REQ-018 Entries below the operation depth SHALL be preserved unchanged.
REQ-019 Underflow SHALL be defined as pop > count; overflow SHALL be defined as count - pop + push > DEPTH; pop=3 SHALL be illegal.
REQ-020 An underflow, overflow or illegal operation SHALL cause no state change (count and all entries unchanged).
REQ-021 push=1 at full with pop>=1 SHALL be legal (no overflow).
REQ-022 pop=2 with count=2 and push=0 SHALL leave the stack empty, tos=nos=0.
REQ-023 push=0, pop=0 SHALL be a no-op.
REQ-024 With trap nonzero, all further operations SHALL be ignored until reset (halted state).

Reset
REQ-025 reset low SHALL asynchronously force count=0, empty=1, full=0, tos=0, nos=0, trap=0.
REQ-026 Entry storage contents SHALL not be required to reset; unoccupied entries are never observable.
REQ-027 Reset asserted mid-operation SHALL take priority over any push/pop on the same edge; first operation is accepted on the first rising edge with reset high.

Configuration
REQ-028 Macro OPERAND_STACK_TRAP_EN SHALL enable trap reporting.
REQ-029 With OPERAND_STACK_TRAP_EN defined: violations set trap to the code of REQ-013 (first violation wins, sticky) and enter the halted state of REQ-024.
REQ-030 Without OPERAND_STACK_TRAP_EN: trap SHALL be constant 0, violating operations SHALL be discarded silently per REQ-020, and no halted state exists.

Verification
REQ-031 Push 0x1, 0x2, 0x3 on three edges -> count=3, tos=0x3, nos=0x2, empty=0.
REQ-032 From stack [0x5,0x7] (tos 0x7), pop=2,push=1,data_in=0xC -> count=1, tos=0xC, nos=0.
REQ-033 From empty, pop=1 (trap enabled) -> trap=2, count=0, tos=0; subsequent push 0x9 ignored, count stays 0.
REQ-034 Fill DEPTH=16 entries, then push 0xAA -> trap=1, count=16, tos unchanged; with trap disabled trap=0, count=16, next pop=1 yields count=15.
REQ-035 At full, pop=1,push=1,data_in=0xBEEF -> count=16, tos=0xBEEF, trap=0, full=1.
REQ-036 Drive reset low asynchronously between edges with count=4 -> count=0, empty=1, tos=0 before next edge.

Source files
------------

// File: rtl/operand_stack.sv
// Register-file operand stack: pop-then-push per edge, zero-latency tos/nos/count views.
// Define OPERAND_STACK_TRAP_EN for sticky trap reporting and halt-on-violation.
module operand_stack #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [1:0]                   pop,
   input  logic [WIDTH-1:0]             data_in,
   output logic [WIDTH-1:0]             tos,
   output logic [WIDTH-1:0]             nos,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full,
   output logic [2:0]                   trap
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    cnt_q;
   logic [CW:0]      cnt_ext;
   logic [CW:0]      pop_ext;
   logic [CW:0]      push_ext;
   logic [CW:0]      new_cnt;
   logic             illegal;
   logic             underflow;
   logic             overflow;
   logic [2:0]       viol_code;
   logic             halted;
   logic             accept;
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    tos_idx;
   logic [AW-1:0]    nos_idx;

   // Legality is judged on the combined pop-then-push result before any state moves.
   always_comb begin
      cnt_ext   = {1'b0, cnt_q};
      pop_ext   = (CW+1)'(pop);
      push_ext  = (CW+1)'(push);
      new_cnt   = cnt_ext - pop_ext + push_ext;
      illegal   = (pop == 2'd3);
      underflow = !illegal && (pop_ext > cnt_ext);
      overflow  = !illegal && !underflow && (new_cnt > (CW+1)'(DEPTH));
      if (illegal)
         viol_code = 3'd3;
      else if (underflow)
         viol_code = 3'd2;
      else if (overflow)
         viol_code = 3'd1;
      else
         viol_code = 3'd0;
      accept    = !halted && (viol_code == 3'd0);
      wr_idx    = AW'(cnt_q - CW'(pop));
      tos_idx   = AW'(cnt_q - CW'(1));
      nos_idx   = AW'(cnt_q - CW'(2));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else if (accept)
         cnt_q <= CW'(new_cnt);
   end

   // Entry storage carries no reset; slots at or above count are never read out.
   always_ff @(posedge clk) begin
      if (accept && push)
         mem[wr_idx] <= data_in;
   end

`ifdef OPERAND_STACK_TRAP_EN
   logic [2:0] trap_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         trap_q <= 3'd0;
      else if (!halted && (viol_code != 3'd0))
         trap_q <= viol_code;
   end

   assign halted = (trap_q != 3'd0);
   assign trap   = trap_q;
`else
   assign halted = 1'b0;
   assign trap   = 3'd0;
`endif

   assign count = cnt_q;
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));
   assign tos   = (cnt_q >= CW'(1)) ? mem[tos_idx] : '0;
   assign nos   = (cnt_q >= CW'(2)) ? mem[nos_idx] : '0;

endmodule

// File: tb/tb_operand_stack.sv
// Directed self-checking bench for operand_stack (WIDTH=64, DEPTH=16); trap checks
// follow the OPERAND_STACK_TRAP_EN build selection.
module tb_operand_stack;

   logic        clk;
   logic        reset;
   logic        push;
   logic [1:0]  pop;
   logic [63:0] data_in;
   logic [63:0] tos;
   logic [63:0] nos;
   logic [4:0]  count;
   logic        empty;
   logic        full;
   logic [2:0]  trap;

   int checks = 0;
   int errors = 0;

   operand_stack #(.WIDTH(64), .DEPTH(16)) dut (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .data_in (data_in),
      .tos     (tos),
      .nos     (nos),
      .count   (count),
      .empty   (empty),
      .full    (full),
      .trap    (trap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic op(input logic p, input logic [1:0] pp, input logic [63:0] d);
      @(negedge clk);
      push    = p;
      pop     = pp;
      data_in = d;
      @(posedge clk);
      #1;
      push    = 1'b0;
      pop     = 2'd0;
      data_in = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset   = 1'b0;
      push    = 1'b0;
      pop     = 2'd0;
      data_in = '0;
      #3;
      check("rst_count", 64'(count), 64'd0);
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_full",  64'(full),  64'd0);
      check("rst_tos",   tos,        64'd0);
      check("rst_nos",   nos,        64'd0);
      check("rst_trap",  64'(trap),  64'd0);
      @(negedge clk);
      reset = 1'b1;

      // Three pushes
      op(1'b1, 2'd0, 64'h1);
      op(1'b1, 2'd0, 64'h2);
      op(1'b1, 2'd0, 64'h3);
      check("push3_count", 64'(count), 64'd3);
      check("push3_tos",   tos,        64'h3);
      check("push3_nos",   nos,        64'h2);
      check("push3_empty", 64'(empty), 64'd0);

      // Replace tos
      op(1'b1, 2'd1, 64'h44);
      check("repl_count", 64'(count), 64'd3);
      check("repl_tos",   tos,        64'h44);
      check("repl_nos",   nos,        64'h2);

      // No-op
      op(1'b0, 2'd0, 64'hDEAD);
      check("nop_count", 64'(count), 64'd3);
      check("nop_tos",   tos,        64'h44);

      op(1'b0, 2'd2, 64'h0);
      check("pop2_count", 64'(count), 64'd1);
      check("pop2_tos",   tos,        64'h1);
      check("pop2_nos",   nos,        64'h0);
      op(1'b0, 2'd1, 64'h0);
      check("pop1_empty", 64'(empty), 64'd1);
      check("pop1_tos",   tos,        64'h0);

      // Binary op: [5,7] -> C
      op(1'b1, 2'd0, 64'h5);
      op(1'b1, 2'd0, 64'h7);
      op(1'b1, 2'd2, 64'hC);
      check("binop_count", 64'(count), 64'd1);
      check("binop_tos",   tos,        64'hC);
      check("binop_nos",   nos,        64'h0);
      op(1'b0, 2'd1, 64'h0);

      // pop=2 at count=2 empties the stack
      op(1'b1, 2'd0, 64'h5);
      op(1'b1, 2'd0, 64'h7);
      op(1'b0, 2'd2, 64'h0);
      check("pop2_2_count", 64'(count), 64'd0);
      check("pop2_2_empty", 64'(empty), 64'd1);
      check("pop2_2_tos",   tos,        64'h0);
      check("pop2_2_nos",   nos,        64'h0);

      // Fill to DEPTH
      for (int i = 0; i < 16; i++) op(1'b1, 2'd0, 64'h100 + 64'(i));
      check("fill_count", 64'(count), 64'd16);
      check("fill_full",  64'(full),  64'd1);
      check("fill_tos",   tos,        64'h10F);
      check("fill_nos",   nos,        64'h10E);

      // Replace at full is legal
      op(1'b1, 2'd1, 64'hBEEF);
      check("fullrep_count", 64'(count), 64'd16);
      check("fullrep_tos",   tos,        64'hBEEF);
      check("fullrep_nos",   nos,        64'h10E);
      check("fullrep_trap",  64'(trap),  64'd0);
      check("fullrep_full",  64'(full),  64'd1);

      op(1'b0, 2'd1, 64'h0);
      check("unfill_count", 64'(count), 64'd15);
      check("unfill_tos",   tos,        64'h10E);
      op(1'b1, 2'd0, 64'h77);
      check("refill_tos", tos, 64'h77);

      // Overflow
      op(1'b1, 2'd0, 64'hAA);
      check("ovf_count", 64'(count), 64'd16);
      check("ovf_tos",   tos,        64'h77);
`ifdef OPERAND_STACK_TRAP_EN
      check("ovf_trap", 64'(trap), 64'd1);
      op(1'b0, 2'd1, 64'h0);
      check("halt_count", 64'(count), 64'd16);
      check("halt_tos",   tos,        64'h77);
      check("halt_trap",  64'(trap),  64'd1);

      do_reset();
      op(1'b0, 2'd1, 64'h0);
      check("unf_trap",  64'(trap),  64'd2);
      check("unf_count", 64'(count), 64'd0);
      check("unf_tos",   tos,        64'h0);
      op(1'b1, 2'd0, 64'h9);
      check("unf_halt_count", 64'(count), 64'd0);
      check("unf_halt_trap",  64'(trap),  64'd2);

      do_reset();
      op(1'b1, 2'd0, 64'h11);
      op(1'b1, 2'd0, 64'h22);
      op(1'b0, 2'd3, 64'h0);
      check("ill_trap",  64'(trap),  64'd3);
      check("ill_count", 64'(count), 64'd2);
      check("ill_tos",   tos,        64'h22);
`else
      check("ovf_trap", 64'(trap), 64'd0);
      op(1'b0, 2'd1, 64'h0);
      check("post_ovf_count", 64'(count), 64'd15);
      check("post_ovf_tos",   tos,        64'h10E);

      do_reset();
      op(1'b0, 2'd1, 64'h0);
      check("unf_count", 64'(count), 64'd0);
      check("unf_trap",  64'(trap),  64'd0);
      op(1'b1, 2'd0, 64'h9);
      check("unf_next_count", 64'(count), 64'd1);
      check("unf_next_tos",   tos,        64'h9);
      op(1'b0, 2'd2, 64'h0);
      check("unf2_count", 64'(count), 64'd1);
      check("unf2_tos",   tos,        64'h9);

      op(1'b1, 2'd0, 64'h22);
      op(1'b0, 2'd3, 64'h0);
      check("ill_count", 64'(count), 64'd2);
      check("ill_tos",   tos,        64'h22);
      check("ill_trap",  64'(trap),  64'd0);
`endif

      // Asynchronous reset between edges
      do_reset();
      for (int i = 0; i < 4; i++) op(1'b1, 2'd0, 64'h30 + 64'(i));
      check("pre_arst_count", 64'(count), 64'd4);
      #2;
      reset   = 1'b0;
      push    = 1'b1;
      data_in = 64'h55;
      #1;
      check("arst_count", 64'(count), 64'd0);
      check("arst_empty", 64'(empty), 64'd1);
      check("arst_tos",   tos,        64'h0);
      @(posedge clk);
      #1;
      check("arst_hold_count", 64'(count), 64'd0);
      @(negedge clk);
      push    = 1'b0;
      data_in = '0;
      reset   = 1'b1;
      op(1'b1, 2'd0, 64'h66);
      check("first_op_count", 64'(count), 64'd1);
      check("first_op_tos",   tos,        64'h66);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
